// File: rtl/i2s_tx_pkg.sv
// Shared types and elaboration helpers for the I2S/TDM transmitter.
//   fmt_t  : serial framing latched at each frame start
//   idx_w  : counter width for a modulus n (never below one bit)
package i2s_tx_pkg;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_TDM = 1'b1
  } fmt_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: bck toggles every BCK_DIV clk; fall_c flags the clk whose
// closing edge drives bck low.
//   clk, reset : system clock, asynchronous active-high reset
//   ena        : 0 holds the divider cleared (synchronous)
//   bck        : bit clock (registered)
//   fall_c     : combinational one-clk strobe preceding each bck falling edge
module i2s_bck_gen
  import i2s_tx_pkg::*;
#(
  parameter int unsigned BCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  output logic bck,
  output logic fall_c
);

  localparam int unsigned CW = idx_w(BCK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BCK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bck_q, bck_d;

  // Half-period counter and toggle
  always_comb begin
    cnt_d  = cnt_q;
    bck_d  = bck_q;
    fall_c = 1'b0;
    if (!ena) begin
      cnt_d = '0;
      bck_d = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      bck_d  = ~bck_q;
      fall_c = bck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      bck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bck_q <= bck_d;
    end
  end

  assign bck = bck_q;

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / TDM serial transmitter: one multi-channel frame per valid/ready
// handshake, double-buffered (holding + shift register), serialised MSB-first.
// Optional build macro: I2S_TX_MUTE_EN adds the 'mute' input (sampled at b=0).
//   clk, reset   : system clock, asynchronous active-high reset
//   ena          : 0 keeps the serialiser in its reset state (synchronous)
//   tdm_mode     : 0 = I2S, 1 = TDM, latched at frame start
//   s_valid/s_ready/s_data : frame input, ch k at s_data[k*WORD_W +: WORD_W]
//   i2s_bck/i2s_ws/i2s_d0  : serial port, data/ws change on bck fall
//   frame_start  : one-clk pulse as bit 0 of a frame begins
//   underrun     : one-clk pulse when a frame starts with no data held
module i2s_tdm_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned WORD_W  = 24,
  parameter int unsigned SLOT_W  = 32,
  parameter int unsigned BCK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ena,
  input  logic                     tdm_mode,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_CH*WORD_W-1:0] s_data,
  output logic                     i2s_bck,
  output logic                     i2s_ws,
  output logic                     i2s_d0,
  output logic                     frame_start,
  output logic                     underrun
`ifdef I2S_TX_MUTE_EN
  ,
  input  logic                     mute
`endif
);

  localparam int unsigned FRAME = NUM_CH * SLOT_W;
  localparam int unsigned BW    = idx_w(FRAME);
  localparam int unsigned DW    = NUM_CH * WORD_W;
  localparam logic [BW-1:0] B_LAST   = BW'(FRAME - 1);
  localparam logic [BW-1:0] I2S_WS_LO = BW'(SLOT_W - 1);
  localparam logic [BW-1:0] I2S_WS_HI = BW'(2 * SLOT_W - 2);

  if (SLOT_W < WORD_W || BCK_DIV < 1 || NUM_CH < 1) begin : g_bad_cfg
    $error("i2s_tdm_tx: invalid NUM_CH/WORD_W/SLOT_W/BCK_DIV combination");
  end

  logic fall_c;
  logic mute_c;

`ifdef I2S_TX_MUTE_EN
  assign mute_c = mute;
`else
  assign mute_c = 1'b0;
`endif

  i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck_gen (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .bck   (i2s_bck),
    .fall_c(fall_c)
  );

  logic [BW-1:0]    b_q, b_d;
  logic [FRAME-1:0] sh_q, sh_d;
  logic [DW-1:0]    hold_q, hold_d;
  logic             s_ready_q, s_ready_d;
  fmt_t             fmt_q, fmt_d;
  logic             ws_q, ws_d;
  logic             d0_q, d0_d;
  logic             fs_q, fs_d;
  logic             ur_q, ur_d;

  // Place each channel word at the top of its slot, zero padding below
  function automatic logic [FRAME-1:0] pack_frame(input logic [DW-1:0] h);
    logic [FRAME-1:0] f;
    f = '0;
    for (int unsigned s = 0; s < NUM_CH; s++) begin
      f[FRAME-1-s*SLOT_W -: WORD_W] = h[s*WORD_W +: WORD_W];
    end
    return f;
  endfunction

  // Bit counter, frame load, handshake and serial outputs
  always_comb begin
    b_d       = b_q;
    sh_d      = sh_q;
    hold_d    = hold_q;
    s_ready_d = s_ready_q;
    fmt_d     = fmt_q;
    ws_d      = ws_q;
    d0_d      = d0_q;
    fs_d      = 1'b0;
    ur_d      = 1'b0;

    if (fall_c) begin
      if (b_q == B_LAST) begin
        b_d   = '0;
        fs_d  = 1'b1;
        // I2S framing only exists for two channels; wider frames use TDM sync
        fmt_d = (tdm_mode || NUM_CH != 2) ? FMT_TDM : FMT_I2S;
        if (mute_c) begin
          sh_d = '0;
        end else if (!s_ready_q) begin
          sh_d = pack_frame(hold_q);
        end else begin
          sh_d = '0;
          ur_d = 1'b1;
        end
        s_ready_d = 1'b1;
      end else begin
        b_d  = b_q + BW'(1);
        sh_d = sh_q << 1;
      end
      d0_d = sh_d[FRAME-1];
      ws_d = (fmt_d == FMT_TDM) ? (b_d == B_LAST)
                                : (b_d >= I2S_WS_LO && b_d <= I2S_WS_HI);
    end

    // Accept only into an empty holding register; a frame-start load in the
    // same clk cannot coincide since s_ready_q is then still low or already empty
    if (s_valid && s_ready_q) begin
      hold_d    = s_data;
      s_ready_d = 1'b0;
    end

    if (!ena) begin
      b_d       = B_LAST;
      sh_d      = '0;
      hold_d    = '0;
      s_ready_d = 1'b1;
      fmt_d     = FMT_I2S;
      ws_d      = 1'b0;
      d0_d      = 1'b0;
      fs_d      = 1'b0;
      ur_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_q       <= B_LAST;
      sh_q      <= '0;
      hold_q    <= '0;
      s_ready_q <= 1'b1;
      fmt_q     <= FMT_I2S;
      ws_q      <= 1'b0;
      d0_q      <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
    end else begin
      b_q       <= b_d;
      sh_q      <= sh_d;
      hold_q    <= hold_d;
      s_ready_q <= s_ready_d;
      fmt_q     <= fmt_d;
      ws_q      <= ws_d;
      d0_q      <= d0_d;
      fs_q      <= fs_d;
      ur_q      <= ur_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign i2s_ws      = ws_q;
  assign i2s_d0      = d0_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench for i2s_tdm_tx (NUM_CH=2, WORD_W=24, SLOT_W=32, BCK_DIV=2):
// each frame is captured bit by bit (one sample per bck) and compared with
// hand-built 64-bit data and ws patterns.
module tb_i2s_tdm_tx;

  logic        clk = 1'b0;
  logic        reset, ena, tdm_mode, s_valid;
  logic        s_ready;
  logic [47:0] s_data;
  logic        i2s_bck, i2s_ws, i2s_d0, frame_start, underrun;
`ifdef I2S_TX_MUTE_EN
  logic        mute;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int last_acc, last_rdy_low;

  // ws over one frame, bit (63-b) holds ws at bit index b
  localparam logic [63:0] WS_I2S = 64'h0000_0001_FFFF_FFFE;
  localparam logic [63:0] WS_TDM = 64'h0000_0000_0000_0001;

  always #5 clk = ~clk;

  i2s_tdm_tx #(.NUM_CH(2), .WORD_W(24), .SLOT_W(32), .BCK_DIV(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .tdm_mode   (tdm_mode),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .i2s_bck    (i2s_bck),
    .i2s_ws     (i2s_ws),
    .i2s_d0     (i2s_d0),
    .frame_start(frame_start),
    .underrun   (underrun)
`ifdef I2S_TX_MUTE_EN
    ,
    .mute       (mute)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for frame_start, then sample d0/ws once per bck for 64 bits
  task automatic collect(output logic [63:0] d, output logic [63:0] w,
                         output logic ur, output logic rdy0, output int waits);
    waits = 0;
    while (!frame_start && waits < 400) begin
      @(negedge clk);
      waits++;
    end
    ur = underrun;
    rdy0 = s_ready;
    last_acc = 0;
    last_rdy_low = 0;
    d = '0;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      d[63-i] = i2s_d0;
      w[63-i] = i2s_ws;
      for (int k = 0; k < 4; k++) begin
        if (s_valid && s_ready) last_acc++;
        if (!s_ready) last_rdy_low++;
        @(negedge clk);
      end
    end
  endtask

  task automatic frame_chk(input string tag, input logic [63:0] ed, input logic [63:0] ew,
                           input logic eur, input int ewaits);
    logic [63:0] d, w;
    logic ur, rdy0;
    int waits;
    collect(d, w, ur, rdy0, waits);
    chk({tag, "_wait"}, 64'(waits), 64'(ewaits));
    chk({tag, "_d0"}, d, ed);
    chk({tag, "_ws"}, w, ew);
    chk({tag, "_underrun"}, 64'(ur), 64'(eur));
    chk({tag, "_ready_at_start"}, 64'(rdy0), 64'd1);
  endtask

  // Single-clk push into an empty holding register
  task automatic push(input logic [23:0] l, input logic [23:0] r);
    s_valid = 1'b1;
    s_data  = {r, l};
    @(negedge clk);
    s_valid = 1'b0;
    chk("push_ready_low", 64'(s_ready), 64'd0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    ena      = 1'b1;
    tdm_mode = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
`ifdef I2S_TX_MUTE_EN
    mute     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_bck", 64'(i2s_bck), 64'd0);
    chk("rst_ws", 64'(i2s_ws), 64'd0);
    chk("rst_d0", 64'(i2s_d0), 64'd0);
    chk("rst_fs", 64'(frame_start), 64'd0);
    chk("rst_ur", 64'(underrun), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);

    // First frame starts 4 clk after release with nothing held
    reset = 1'b0;
    frame_chk("f0", 64'd0, WS_I2S, 1'b1, 4);

    // Full-scale negative / positive samples in I2S
    push(24'h800001, 24'h7FFFFF);
    frame_chk("i2s_lr", 64'h8000_0100_7FFF_FF00, WS_I2S, 1'b0, 255);

    // Three starved frames, 256 clk apart
    frame_chk("ur1", 64'd0, WS_I2S, 1'b1, 0);
    frame_chk("ur2", 64'd0, WS_I2S, 1'b1, 0);
    frame_chk("ur3", 64'd0, WS_I2S, 1'b1, 0);

    // Back-to-back: valid held high, one accept per frame
    s_valid = 1'b1;
    s_data  = {24'hABCDEF, 24'h123456};
    frame_chk("b2b0", 64'd0, WS_I2S, 1'b1, 0);
    chk("b2b0_acc", 64'(last_acc), 64'd1);
    chk("b2b0_rdy_low", 64'(last_rdy_low), 64'd255);
    frame_chk("b2b1", 64'h1234_5600_ABCD_EF00, WS_I2S, 1'b0, 0);
    chk("b2b1_acc", 64'(last_acc), 64'd1);
    chk("b2b1_rdy_low", 64'(last_rdy_low), 64'd255);
    frame_chk("b2b2", 64'h1234_5600_ABCD_EF00, WS_I2S, 1'b0, 0);
    s_valid = 1'b0;

    // tdm_mode raised after b=0: current frame stays I2S
    tdm_mode = 1'b1;
    frame_chk("mode_mid", 64'h1234_5600_ABCD_EF00, WS_I2S, 1'b0, 0);
    frame_chk("tdm_ur", 64'd0, WS_TDM, 1'b1, 0);
    push(24'hC0FFEE, 24'h000001);
    frame_chk("tdm_data", 64'hC0FF_EE00_0000_0100, WS_TDM, 1'b0, 255);

    // Reset mid-frame with a frame held: immediate clear, holding discarded
    tdm_mode = 1'b0;
    push(24'h111111, 24'h222222);
    repeat (30) @(negedge clk);
    n = 0;
    while (!i2s_bck && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_bck", 64'(i2s_bck), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_bck", 64'(i2s_bck), 64'd0);
    chk("mid_rst_ws", 64'(i2s_ws), 64'd0);
    chk("mid_rst_d0", 64'(i2s_d0), 64'd0);
    chk("mid_rst_fs", 64'(frame_start), 64'd0);
    chk("mid_rst_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    frame_chk("post_rst", 64'd0, WS_I2S, 1'b1, 4);

`ifdef I2S_TX_MUTE_EN
    // Muted frame consumes holding without underrun; data resumes next frame
    push(24'h777777, 24'h333333);
    mute = 1'b1;
    frame_chk("muted", 64'd0, WS_I2S, 1'b0, 255);
    mute = 1'b0;
    push(24'h5A5A5A, 24'hA5A5A5);
    frame_chk("unmuted", 64'h5A5A_5A00_A5A5_A500, WS_I2S, 1'b0, 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
